pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised next-generation program counter for the single-cycle / multi-cycle RISC-V core.
- Holds the byte-addressed fetch PC and sequences PC+4, the conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU), JAL and JALR.
- Supports stall and a fetch valid/ready handshake to instruction memory.
- Sits between the control unit/ALU and instruction memory. Provides the link address for the register-file write-back.

Parameters:
- ADDR_WIDTH, 32, width of the PC and fetch address in bits (byte address).
- DATA_WIDTH, 32, width of the offset and JALR base operands (RISC_V_DATA_WIDTH).
- RESET_ADDR, 0, PC value loaded on reset; must be 4-byte aligned.
- INSTR_BYTES, 4, sequential increment in bytes.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hold the PC and ignore all control this cycle
- ctrl_branch  input  1  conditional branch instruction in execute
- branch_funct3  input  3  RISC-V funct3 branch condition encoding
- ctrl_jal  input  1  JAL instruction
- ctrl_jalr  input  1  JALR instruction
- alu_zero  input  1  rs1 == rs2
- alu_lt  input  1  rs1 < rs2, signed
- alu_ltu  input  1  rs1 < rs2, unsigned
- offset  input  DATA_WIDTH  sign-extended byte immediate
- jalr_base  input  DATA_WIDTH  rs1 value for JALR
- fetch_ready  input  1  instruction memory accepts the address
- trap_clear  input  1  leave TRAP state (see Optional Feature)
- fetch_address  output  ADDR_WIDTH  current PC
- fetch_valid  output  1  fetch_address is valid for fetch
- link_address  output  ADDR_WIDTH  fetch_address + INSTR_BYTES, combinational
- redirect  output  1  taken branch or jump accepted this cycle (registered pulse)
- trap  output  1  misaligned target trap pending

Behaviour:
- Reset (async, any state, including mid-stall or mid-trap): fetch_address = RESET_ADDR, fetch_valid = 0, redirect = 0, trap = 0, state = BOOT.
- States:
  - BOOT → RUN on the first clock after reset release; fetch_valid = 1 from that edge.
  - RUN: fetch_valid = 1.
  - TRAP: fetch_valid = 0.
- Advance condition: state == RUN && fetch_valid && fetch_ready && !stall. If the condition is false, the PC holds and redirect = 0 on the next cycle.
- Branch taken by funct3:
  - 000 zero
  - 001 !zero
  - 100 lt
  - 101 !lt
  - 110 ltu
  - 111 !ltu
  - 010 / 011: never taken.
- Target priority: jalr > jal > taken branch > sequential.
  - jalr: ((jalr_base + offset) truncated to ADDR_WIDTH) with bit0 cleared.
  - jal / branch: fetch_address + offset[ADDR_WIDTH-1:0].
  - sequential: fetch_address + INSTR_BYTES.
- All arithmetic is modulo 2^ADDR_WIDTH: wrap-around at the top of the address space is silent.
- redirect = 1 for exactly one cycle after an accepted non-sequential update.
- A control input presented while stalled or while fetch_ready = 0 is not latched; the control unit re-presents it.
- Latency: a new PC is visible one clock after the advance edge.

Optional Feature:
- Macro: PC_SEQUENCER_MISALIGN_TRAP_EN.
- Enabled:
  - A selected target with bits [1:0] != 0 (after the JALR bit0 clear) does not update the PC.
  - State moves to TRAP, trap = 1, fetch_address holds the faulting instruction's PC.
  - TRAP → RUN on trap_clear; the PC then advances to fetch_address + INSTR_BYTES.
  - trap_clear is ignored in other states. Reset exits TRAP.
- Disabled:
  - Target bits [1:0] are forced to 0.
  - TRAP is unreachable and trap is tied to 0.
  - trap_clear is unused.

Test Plan:
- Reset release: hold rst 3 cycles, RESET_ADDR = 0x100, then fetch_ready = 1 with no control → fetch_address sequence 0x100 (fetch_valid 0), 0x100, 0x104, 0x108; fetch_valid = 1 from the second cycle.
- BNE: PC = 0x20, ctrl_branch = 1, funct3 = 001, alu_zero = 0, offset = −8 → next PC 0x18, redirect pulse 1 cycle. Same with alu_zero = 1 → 0x24, redirect = 0.
- JALR priority: PC = 0x40, ctrl_jalr = ctrl_jal = ctrl_branch = 1, jalr_base = 0x1001, offset = 4 → next PC 0x1004; link_address = 0x44 during the cycle.
- Stall / handshake: PC = 0x80, stall = 1 for 2 cycles, then fetch_ready = 0 for 1 cycle with ctrl_jal and offset 0x10 → PC stays 0x80 throughout; JAL accepted once both are clear → 0x90.
- Wrap: ADDR_WIDTH = 8, PC = 0xFC, sequential → 0x00; jal with offset = 8 from 0xFC → 0x04.
- Trap (macro on): PC = 0x10, jal with offset = 6 → trap = 1, fetch_valid = 0, PC 0x10 held for 5 cycles; trap_clear pulse → PC 0x14, RUN. Macro off, same stimulus → PC 0x14 (0x16 with bits [1:0] cleared), trap = 0. Async rst asserted during TRAP → PC RESET_ADDR immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch program counter for the RISC-V core.
// Sequences PC+INSTR_BYTES, conditional branches, JAL and JALR, honours
// stall and the fetch valid/ready handshake, and exposes the link address.
// Optional feature macro: PC_SEQUENCER_MISALIGN_TRAP_EN
//   defined   -> a misaligned jump/branch target parks the sequencer in TRAP
//   undefined -> target bits [1:0] are forced to zero and trap stays low
module pc_sequencer #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0,
  parameter int                    INSTR_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  ctrl_branch,
  input  logic [2:0]            branch_funct3,
  input  logic                  ctrl_jal,
  input  logic                  ctrl_jalr,
  input  logic                  alu_zero,
  input  logic                  alu_lt,
  input  logic                  alu_ltu,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [DATA_WIDTH-1:0] jalr_base,
  input  logic                  fetch_ready,
  input  logic                  trap_clear,
  output logic [ADDR_WIDTH-1:0] fetch_address,
  output logic                  fetch_valid,
  output logic [ADDR_WIDTH-1:0] link_address,
  output logic                  redirect,
  output logic                  trap
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    fetch_valid_q, fetch_valid_d;
  logic                    redirect_q, redirect_d;
  logic                    trap_q, trap_d;

  logic                    advance;
  logic                    branch_taken;
  logic                    non_seq;
  logic [DATA_WIDTH-1:0]   jalr_sum;
  logic [ADDR_WIDTH-1:0]   jalr_target;
  logic [ADDR_WIDTH-1:0]   rel_target;
  logic [ADDR_WIDTH-1:0]   seq_target;
  logic [ADDR_WIDTH-1:0]   raw_target;
  logic [ADDR_WIDTH-1:0]   target;
  logic                    misaligned;

  assign fetch_address = pc_q;
  assign fetch_valid   = fetch_valid_q;
  assign redirect      = redirect_q;
  assign trap          = trap_q;
  assign link_address  = pc_q + ADDR_WIDTH'(INSTR_BYTES);

  // Decode the branch condition and pick the candidate target by priority
  always_comb begin
    branch_taken = 1'b0;
    case (branch_funct3)
      3'b000:  branch_taken = alu_zero;
      3'b001:  branch_taken = !alu_zero;
      3'b100:  branch_taken = alu_lt;
      3'b101:  branch_taken = !alu_lt;
      3'b110:  branch_taken = alu_ltu;
      3'b111:  branch_taken = !alu_ltu;
      default: branch_taken = 1'b0;
    endcase

    jalr_sum    = jalr_base + offset;
    jalr_target = {jalr_sum[ADDR_WIDTH-1:1], 1'b0};
    rel_target  = pc_q + offset[ADDR_WIDTH-1:0];
    seq_target  = pc_q + ADDR_WIDTH'(INSTR_BYTES);

    non_seq    = 1'b1;
    raw_target = seq_target;
    if (ctrl_jalr) begin
      raw_target = jalr_target;
    end else if (ctrl_jal || (ctrl_branch && branch_taken)) begin
      raw_target = rel_target;
    end else begin
      non_seq = 1'b0;
    end

`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
    target     = raw_target;
    misaligned = (raw_target[1:0] != 2'b00);
`else
    target     = {raw_target[ADDR_WIDTH-1:2], 2'b00};
    misaligned = 1'b0;
`endif

    advance = (state_q == RUN) && fetch_valid_q && fetch_ready && !stall;
  end

  // Next-state logic for the BOOT/RUN/TRAP sequencer and its registered outputs
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    redirect_d    = 1'b0;
    trap_d        = trap_q;
    case (state_q)
      BOOT: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
      end
      RUN: begin
        if (advance) begin
          if (misaligned) begin
            state_d       = TRAP;
            fetch_valid_d = 1'b0;
            trap_d        = 1'b1;
          end else begin
            pc_d       = target;
            redirect_d = non_seq;
          end
        end
      end
      TRAP: begin
`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
        if (trap_clear) begin
          state_d       = RUN;
          fetch_valid_d = 1'b1;
          trap_d        = 1'b0;
          pc_d          = seq_target;
        end
`endif
      end
      default: begin
        state_d       = BOOT;
        fetch_valid_d = 1'b0;
        trap_d        = 1'b0;
      end
    endcase
  end

`ifndef PC_SEQUENCER_MISALIGN_TRAP_EN
  // trap_clear has no effect when the misalignment trap is compiled out
  logic unused_trap_clear;
  assign unused_trap_clear = trap_clear;
`endif

  // State and output registers; reset may strike in any state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_ADDR;
      fetch_valid_q <= 1'b0;
      redirect_q    <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      redirect_q    <= redirect_d;
      trap_q        <= trap_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 32-bit instance at RESET_ADDR 0x100
// and an 8-bit instance used to exercise address wrap-around.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        rst_w;
  logic        stall;
  logic        ctrl_branch;
  logic [2:0]  branch_funct3;
  logic        ctrl_jal;
  logic        ctrl_jalr;
  logic        alu_zero;
  logic        alu_lt;
  logic        alu_ltu;
  logic [31:0] offset;
  logic [31:0] jalr_base;
  logic        fetch_ready;
  logic        trap_clear;

  logic [31:0] fetch_address;
  logic        fetch_valid;
  logic [31:0] link_address;
  logic        redirect;
  logic        trap;

  logic [7:0]  w_fetch_address;
  logic        w_fetch_valid;
  logic [7:0]  w_link_address;
  logic        w_redirect;
  logic        w_trap;

  int errors;
  int checks;

  pc_sequencer #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .RESET_ADDR (32'h0000_0100),
    .INSTR_BYTES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .ctrl_branch  (ctrl_branch),
    .branch_funct3(branch_funct3),
    .ctrl_jal     (ctrl_jal),
    .ctrl_jalr    (ctrl_jalr),
    .alu_zero     (alu_zero),
    .alu_lt       (alu_lt),
    .alu_ltu      (alu_ltu),
    .offset       (offset),
    .jalr_base    (jalr_base),
    .fetch_ready  (fetch_ready),
    .trap_clear   (trap_clear),
    .fetch_address(fetch_address),
    .fetch_valid  (fetch_valid),
    .link_address (link_address),
    .redirect     (redirect),
    .trap         (trap)
  );

  pc_sequencer #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .RESET_ADDR (8'hF8),
    .INSTR_BYTES(4)
  ) dut_wrap (
    .clk          (clk),
    .rst          (rst_w),
    .stall        (stall),
    .ctrl_branch  (ctrl_branch),
    .branch_funct3(branch_funct3),
    .ctrl_jal     (ctrl_jal),
    .ctrl_jalr    (ctrl_jalr),
    .alu_zero     (alu_zero),
    .alu_lt       (alu_lt),
    .alu_ltu      (alu_ltu),
    .offset       (offset),
    .jalr_base    (jalr_base),
    .fetch_ready  (fetch_ready),
    .trap_clear   (trap_clear),
    .fetch_address(w_fetch_address),
    .fetch_valid  (w_fetch_valid),
    .link_address (w_link_address),
    .redirect     (w_redirect),
    .trap         (w_trap)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the control inputs for the next edge
  task automatic applyStimulus(input logic br, input logic [2:0] f3, input logic jal,
                               input logic jalr, input logic zero, input logic lt,
                               input logic ltu, input logic [31:0] off,
                               input logic [31:0] base);
    ctrl_branch   = br;
    branch_funct3 = f3;
    ctrl_jal      = jal;
    ctrl_jalr     = jalr;
    alu_zero      = zero;
    alu_lt        = lt;
    alu_ltu       = ltu;
    offset        = off;
    jalr_base     = base;
  endtask

  task automatic clearControls();
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Place the main PC at an aligned address with a single JALR
  task automatic jumpTo(input logic [31:0] addr);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, addr);
    tick();
    clearControls();
  endtask

  // Directed test sequence
  initial begin
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    rst_w       = 1'b1;
    stall       = 1'b0;
    fetch_ready = 1'b0;
    trap_clear  = 1'b0;
    clearControls();

    tick();
    tick();
    tick();
    checkOutput("reset_pc", fetch_address, 32'h100);
    checkOutput("reset_valid", {31'd0, fetch_valid}, 32'd0);
    checkOutput("reset_redirect", {31'd0, redirect}, 32'd0);
    checkOutput("reset_trap", {31'd0, trap}, 32'd0);

    // Wrap-around on the 8-bit instance while the main one stays in reset
    rst_w       = 1'b0;
    fetch_ready = 1'b1;
    tick();
    checkOutput("wrap_boot_pc", {24'd0, w_fetch_address}, 32'hF8);
    tick();
    checkOutput("wrap_pc_fc", {24'd0, w_fetch_address}, 32'hFC);
    tick();
    checkOutput("wrap_seq", {24'd0, w_fetch_address}, 32'h00);
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0);
    tick();
    checkOutput("wrap_back_fc", {24'd0, w_fetch_address}, 32'hFC);
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
    tick();
    clearControls();
    checkOutput("wrap_jal", {24'd0, w_fetch_address}, 32'h04);
    checkOutput("wrap_jal_redirect", {31'd0, w_redirect}, 32'd1);
    rst_w = 1'b1;

    // Main instance reset release: BOOT then sequential fetch
    rst = 1'b0;
    checkOutput("boot_pc", fetch_address, 32'h100);
    checkOutput("boot_valid", {31'd0, fetch_valid}, 32'd0);
    tick();
    checkOutput("run_pc0", fetch_address, 32'h100);
    checkOutput("run_valid", {31'd0, fetch_valid}, 32'd1);
    tick();
    checkOutput("run_pc1", fetch_address, 32'h104);
    tick();
    checkOutput("run_pc2", fetch_address, 32'h108);
    checkOutput("run_link", link_address, 32'h10C);

    // BNE taken then not taken
    jumpTo(32'h20);
    checkOutput("jump_to_20", fetch_address, 32'h20);
    applyStimulus(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
    tick();
    clearControls();
    checkOutput("bne_taken_pc", fetch_address, 32'h18);
    checkOutput("bne_taken_redirect", {31'd0, redirect}, 32'd1);
    tick();
    checkOutput("redirect_pulse_end", {31'd0, redirect}, 32'd0);
    checkOutput("after_bne_seq", fetch_address, 32'h1C);
    jumpTo(32'h20);
    applyStimulus(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
    tick();
    checkOutput("bne_not_taken_pc", fetch_address, 32'h24);
    checkOutput("bne_not_taken_redirect", {31'd0, redirect}, 32'd0);

    // Other funct3 encodings
    applyStimulus(1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    checkOutput("blt_taken", fetch_address, 32'h34);
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10, 32'h0);
    tick();
    checkOutput("f3_010_never", fetch_address, 32'h38);
    checkOutput("f3_010_redirect", {31'd0, redirect}, 32'd0);
    applyStimulus(1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    tick();
    checkOutput("bgeu_taken", fetch_address, 32'h48);
    applyStimulus(1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    checkOutput("bge_not_taken", fetch_address, 32'h4C);
    applyStimulus(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFE0, 32'h0);
    tick();
    checkOutput("bltu_taken", fetch_address, 32'h2C);
    clearControls();

    // JALR wins over JAL and a taken branch
    jumpTo(32'h40);
    applyStimulus(1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4, 32'h1001);
    checkOutput("jalr_link", link_address, 32'h44);
    tick();
    clearControls();
    checkOutput("jalr_priority", fetch_address, 32'h1004);
    checkOutput("jalr_redirect", {31'd0, redirect}, 32'd1);

    // Stall and fetch_ready hold the PC; JAL accepted once both clear
    jumpTo(32'h80);
    stall = 1'b1;
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    tick();
    checkOutput("stall1_pc", fetch_address, 32'h80);
    checkOutput("stall1_redirect", {31'd0, redirect}, 32'd0);
    tick();
    checkOutput("stall2_pc", fetch_address, 32'h80);
    stall       = 1'b0;
    fetch_ready = 1'b0;
    tick();
    checkOutput("not_ready_pc", fetch_address, 32'h80);
    fetch_ready = 1'b1;
    tick();
    clearControls();
    checkOutput("jal_after_hold", fetch_address, 32'h90);
    checkOutput("jal_after_hold_redirect", {31'd0, redirect}, 32'd1);

    // Misaligned JAL target
    jumpTo(32'h10);
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h6, 32'h0);
    tick();
    clearControls();
`ifdef PC_SEQUENCER_MISALIGN_TRAP_EN
    checkOutput("trap_set", {31'd0, trap}, 32'd1);
    checkOutput("trap_valid", {31'd0, fetch_valid}, 32'd0);
    checkOutput("trap_redirect", {31'd0, redirect}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("trap_hold_pc", fetch_address, 32'h10);
      tick();
    end
    checkOutput("trap_still_set", {31'd0, trap}, 32'd1);
    trap_clear = 1'b1;
    tick();
    trap_clear = 1'b0;
    checkOutput("trap_clear_pc", fetch_address, 32'h14);
    checkOutput("trap_clear_valid", {31'd0, fetch_valid}, 32'd1);
    checkOutput("trap_clear_trap", {31'd0, trap}, 32'd0);
    applyStimulus(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h6, 32'h0);
    tick();
    clearControls();
    checkOutput("trap_again", {31'd0, trap}, 32'd1);
    checkOutput("trap_again_pc", fetch_address, 32'h14);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("trap_async_reset_pc", fetch_address, 32'h100);
    checkOutput("trap_async_reset_trap", {31'd0, trap}, 32'd0);
    checkOutput("trap_async_reset_valid", {31'd0, fetch_valid}, 32'd0);
`else
    checkOutput("misalign_forced_pc", fetch_address, 32'h14);
    checkOutput("misalign_no_trap", {31'd0, trap}, 32'd0);
    checkOutput("misalign_redirect", {31'd0, redirect}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_pc", fetch_address, 32'h100);
    checkOutput("async_reset_valid", {31'd0, fetch_valid}, 32'd0);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
